// File: rtl/ppu_shift_pkg.sv
// Shared constants and types for the PPU background shifter bank.
package ppu_shift_pkg;

    // Default geometry: four lanes of 8-pixel tiles.
    localparam int unsigned DEF_CHANNELS = 4;
    localparam int unsigned DEF_TILE_W   = 8;

    // Lane roles within the default bank.
    localparam int unsigned LANE_PAT_LO  = 0;
    localparam int unsigned LANE_PAT_HI  = 1;
    localparam int unsigned LANE_ATTR_LO = 2;
    localparam int unsigned LANE_ATTR_HI = 3;

    // Operation applied to every lane register on an enabled edge.
    typedef enum logic [1:0] {
        LANE_HOLD   = 2'd0,  // lane register unchanged
        LANE_SHIFT  = 2'd1,  // shift left by one, zero fill
        LANE_RELOAD = 2'd2,  // shift upper half, lower half takes staging
        LANE_LOAD   = 2'd3   // lower half takes staging, upper half kept
    } lane_op_e;

endpackage

// File: rtl/ppu_shift_lane.sv
// One background shift lane: 2*TILE_W shift register, staging latch and
// its staging-full flag. All updates on the falling clock edge.
module ppu_shift_lane
    import ppu_shift_pkg::*;
#(
    parameter int unsigned TILE_W = DEF_TILE_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_ce,
    input  lane_op_e              i_op,
    input  logic                  i_stage_we,
    input  logic [TILE_W-1:0]     i_stage_data,
    output logic [2*TILE_W-1:0]   o_lane,
    output logic                  o_stage_valid
);

    logic [2*TILE_W-1:0] lane_q;
    logic [TILE_W-1:0]   staging_q;
    logic                valid_q;

    // Lane register: shift / reload / load from the current (pre-write) staging value.
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lane_q <= '0;
        end else if (i_ce) begin
            case (i_op)
                LANE_SHIFT:  lane_q <= {lane_q[2*TILE_W-2:0], 1'b0};
                LANE_RELOAD: lane_q <= {lane_q[2*TILE_W-2:TILE_W-1], staging_q};
                LANE_LOAD:   lane_q <= {lane_q[2*TILE_W-1:TILE_W], staging_q};
                default:     lane_q <= lane_q;
            endcase
        end
    end

    // Staging latch: written by the fetch sequencer, read by reload/load.
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            staging_q <= '0;
        end else if (i_ce && i_stage_we) begin
            staging_q <= i_stage_data;
        end
    end

    // Staging-full flag: a concurrent write wins over the consume-clear.
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q <= 1'b0;
        end else if (i_ce) begin
            if (i_stage_we) begin
                valid_q <= 1'b1;
            end else if (i_op == LANE_RELOAD || i_op == LANE_LOAD) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_lane        = lane_q;
    assign o_stage_valid = valid_q;

endmodule

// File: rtl/ppu_bg_shifter_bank.sv
// Bank of PPU background shift lanes with shared phase counter,
// automatic tile-boundary reload, underrun flag and fine-X pixel select.
module ppu_bg_shifter_bank
    import ppu_shift_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned TILE_W   = DEF_TILE_W,
    parameter int unsigned OFFSET_W = $clog2(TILE_W),
    parameter int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_ce,
    input  logic                           i_stage_we,
    input  logic [SEL_W-1:0]               i_stage_sel,
    input  logic [TILE_W-1:0]              i_stage_data,
    input  logic                           i_load_now,
    input  logic                           i_shift,
    input  logic                           i_phase_sync,
    input  logic [OFFSET_W-1:0]            i_fine_x,
    output logic [CHANNELS-1:0]            o_pixel,
    output logic [OFFSET_W-1:0]            o_phase,
    output logic                           o_reload,
    output logic [CHANNELS-1:0]            o_stage_valid,
    output logic                           o_underrun,
    output logic [CHANNELS*2*TILE_W-1:0]   o_debug_data
);

    localparam logic [OFFSET_W-1:0] PHASE_LAST = OFFSET_W'(TILE_W - 1);

    logic [OFFSET_W-1:0] phase_q;
    logic [OFFSET_W-1:0] phase_nxt;
    logic                reload_q;
    logic                reload_nxt;
    logic                underrun_q;
    logic                underrun_nxt;
    lane_op_e            lane_op;
    logic [CHANNELS-1:0] stage_we_vec;
    logic [2*TILE_W-1:0] lane_q [CHANNELS];

    // Lane operation and next phase/reload/underrun; phase sync outranks reload.
    always_comb begin
        lane_op      = LANE_HOLD;
        phase_nxt    = phase_q;
        reload_nxt   = 1'b0;
        underrun_nxt = underrun_q;
        if (i_phase_sync) begin
            phase_nxt    = '0;
            underrun_nxt = 1'b0;
            if (i_shift) begin
                lane_op = LANE_SHIFT;
            end else if (i_load_now) begin
                lane_op = LANE_LOAD;
            end
        end else if (i_shift && (i_load_now || phase_q == PHASE_LAST)) begin
            lane_op    = LANE_RELOAD;
            phase_nxt  = '0;
            reload_nxt = 1'b1;
            if (!(&o_stage_valid)) begin
                underrun_nxt = 1'b1;
            end
        end else if (i_shift) begin
            lane_op   = LANE_SHIFT;
            phase_nxt = (phase_q == PHASE_LAST) ? '0 : phase_q + OFFSET_W'(1);
        end else if (i_load_now) begin
            lane_op = LANE_LOAD;
        end
    end

    // Shared control registers; o_reload holds across disabled cycles.
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase_q    <= '0;
            reload_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else if (i_ce) begin
            phase_q    <= phase_nxt;
            reload_q   <= reload_nxt;
            underrun_q <= underrun_nxt;
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_lane
            // Select values beyond the lane count never match any lane.
            assign stage_we_vec[g] = i_stage_we && (i_stage_sel == SEL_W'(g));

            ppu_shift_lane #(
                .TILE_W (TILE_W)
            ) u_lane (
                .i_clk         (i_clk),
                .i_reset_n     (i_reset_n),
                .i_ce          (i_ce),
                .i_op          (lane_op),
                .i_stage_we    (stage_we_vec[g]),
                .i_stage_data  (i_stage_data),
                .o_lane        (lane_q[g]),
                .o_stage_valid (o_stage_valid[g])
            );

            assign o_debug_data[g*2*TILE_W +: 2*TILE_W] = lane_q[g];
        end
    endgenerate

    logic [TILE_W-1:0] top_half;
    logic [TILE_W-1:0] top_aligned;

    // Fine-X pick from the upper half: bit (2*TILE_W-1-fine_x) of each lane.
    always_comb begin
        top_half    = '0;
        top_aligned = '0;
        o_pixel     = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            top_half    = lane_q[i][2*TILE_W-1:TILE_W];
            top_aligned = top_half << i_fine_x;
            o_pixel[i]  = top_aligned[TILE_W-1];
        end
    end

    assign o_phase    = phase_q;
    assign o_reload   = reload_q;
    assign o_underrun = underrun_q;

endmodule

// File: doc/ppu_bg_shifter_bank.md
# ppu_bg_shifter_bank

Parametrised bank of PPU background shift lanes: CHANNELS independent 2×TILE_W-bit shift registers, each with a staging latch that is auto-reloaded every TILE_W shifts by an internal phase counter, plus fine-X pixel selection per lane. It sits between the PPU tile-fetch sequencer (which writes staging latches) and the pixel multiplexer (which consumes `o_pixel`). It adds per-lane staging, automatic tile-boundary reload, underrun detection and phase resync.

## Interface
- CHANNELS, 4, number of lanes (pattern lo, pattern hi, attribute lo, attribute hi)
- TILE_W, 8, tile width in pixels; lane register is 2×TILE_W bits
- OFFSET_W, $clog2(TILE_W), width of fine-X and phase
- SEL_W, $clog2(CHANNELS) (min 1), staging select width

- i_clk  in  1  clock; all state updates on falling edge
- i_reset_n  in  1  reset i_reset_n, asynchronous, active-low
- i_ce  in  1  clock enable; no state changes when low
- i_stage_we  in  1  write i_stage_data into staging latch of lane i_stage_sel
- i_stage_sel  in  SEL_W  staging target lane; values ≥ CHANNELS ignored
- i_stage_data  in  TILE_W  tile data for staging
- i_load_now  in  1  copy all staging latches into lane low halves without shifting
- i_shift  in  1  shift all lanes left by one
- i_phase_sync  in  1  force phase counter to 0, clear underrun
- i_fine_x  in  OFFSET_W  offset into top TILE_W bits
- o_pixel  out  CHANNELS  bit [2×TILE_W−1−i_fine_x] of each lane
- o_phase  out  OFFSET_W  current phase counter
- o_reload  out  1  one-ce-cycle pulse: auto-reload occurred on previous active edge
- o_stage_valid  out  CHANNELS  per-lane staging-full flags
- o_underrun  out  1  sticky: a reload consumed a non-valid staging latch
- o_debug_data  out  CHANNELS×2×TILE_W  lane registers, lane 0 in LSBs

## Operation
- Reset: lane registers, staging, phase, o_stage_valid, o_underrun, o_reload all 0; o_pixel therefore 0.
- All actions below gated by i_ce; when i_ce=0 all state holds, o_reload holds its value.
- Stage write: staging[sel] <= data, valid[sel] <= 1.
- Shift without reload: lane[2T−1:1] <= lane[2T−2:0], lane[0] <= 0; phase <= phase+1 (mod TILE_W).
- Auto-reload: i_shift with phase==TILE_W−1 (and no i_phase_sync): upper half <= lane[2T−2:T−1], lower half <= staging; all valid <= 0; phase <= 0; o_reload <= 1. If any valid bit was 0, o_underrun <= 1 (lane still loads stale staging).
- i_load_now without i_shift: lower halves <= staging, valid <= 0, upper halves and phase unchanged, no underrun check, o_reload stays 0.
- i_load_now with i_shift: treated as auto-reload regardless of phase (phase <= 0, o_reload <= 1).
- i_phase_sync: phase <= 0, o_underrun <= 0; wins over auto-reload. If i_shift is also asserted, plain shift occurs and no reload takes place.
- Stage write concurrent with reload/load_now: lane takes the old staging value; staging then holds the new data with valid=1 for that lane.
- o_pixel is combinational from lane registers and i_fine_x.

## Timing
- Falling-edge registered; o_pixel valid combinationally after the edge and after i_fine_x changes.
- Reload latency: staged data visible in lane low half immediately after the reload edge; reaches the top bit after TILE_W further shifts.
- o_reload asserts for exactly one ce-cycle following the reload edge.
- Async reset mid-operation clears everything immediately; the first shift after release is phase 0→1.

## Structure
- Package `ppu_shift_pkg`: default CHANNELS/TILE_W constants and lane index constants (LANE_PAT_LO=0, LANE_PAT_HI=1, LANE_ATTR_LO=2, LANE_ATTR_HI=3).
- Sub-module `ppu_shift_lane`: one lane register plus its staging latch and valid bit, instantiated CHANNELS times. Phase counter, underrun, o_reload and select decode live in the top level.

## Test plan
- Reset, then stage lanes 0..3 with 0xA5, 0x3C, 0xFF, 0x00, pulse i_load_now → o_debug_data lane0 = 0x00A5, o_stage_valid = 0000, o_phase = 0.
- Stage 0x81 to lane 0, issue 8 shifts → o_reload pulses after the 8th shift, o_phase = 0, lane0 = 0xA581, o_underrun = 0 only if all four lanes were staged.
- Only lane 0 staged before the 8th shift → o_underrun = 1; it persists through further shifts; i_phase_sync clears it to 0.
- i_fine_x sweep 0..7 with lane0 = 0xA500 → o_pixel[0] = 1,0,1,0,0,1,0,1.
- Stage write on the reload edge (data 0x77) → lane takes the previous staging value; staging = 0x77, valid = 1.
- i_ce = 0 while i_shift/i_stage_we are active → no change in o_debug_data, o_phase or o_stage_valid; mid-sequence async reset → all outputs 0.
